// File: rtl/iact_set_scheduler.sv
// iact_set_scheduler: sequences input-activation delivery into one PE cluster.
// Clears and loads the cluster route config, then lets every enabled iact router
// stream its elements through all of its sets, and pulses done when the pass ends.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; config and router mask captured on start
// CLR   | conf_rst pulse to the cluster controller
// LOAD  | conf_en pulse, cluster latches iact_configs
// RUN   | routers stream elements until every active router is done
// FIN   | done pulse, then back to IDLE
module iact_set_scheduler #(
    parameter int ROUTERS = 3,
    parameter int SETS    = 4,
    parameter int SET_W   = 2,
    parameter int ELEMS   = 16,
    parameter int ELEM_W  = 4,
    parameter int CFG_W   = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     start,
    input  logic [CFG_W-1:0]         cfg_in,
    input  logic [ROUTERS-1:0]       router_mask,
    input  logic [ROUTERS-1:0]       src_valid,
    input  logic [ROUTERS-1:0]       iact_readys,
    output logic [ROUTERS-1:0]       src_ready,
    output logic [ROUTERS-1:0]       iact_enables,
    output logic [SET_W*ROUTERS-1:0] iact_data_set,
    output logic [CFG_W-1:0]         iact_configs,
    output logic                     conf_rst,
    output logic                     conf_en,
    output logic                     busy,
    output logic [ROUTERS-1:0]       set_done,
    output logic                     done
);

    typedef enum logic [2:0] {IDLE, CLR, LOAD, RUN, FIN} state_t;

    localparam logic [ELEM_W-1:0] ELEM_LAST = ELEM_W'(ELEMS - 1);
    localparam logic [ELEM_W-1:0] ELEM_ONE  = ELEM_W'(1);
    localparam logic [SET_W-1:0]  SET_LAST  = SET_W'(SETS - 1);
    localparam logic [SET_W-1:0]  SET_ONE   = SET_W'(1);

    state_t             state;
    logic [ROUTERS-1:0] active;
    logic [ROUTERS-1:0] set_done_q;
    logic [CFG_W-1:0]   cfg_q;
    logic [ELEM_W-1:0]  elem_cnt [ROUTERS];
    logic [SET_W-1:0]   set_cnt  [ROUTERS];
    logic               run_ok;

    // Router gating: only in RUN with the global enable, only for routers still in their pass.
    always_comb begin
        run_ok       = en && (state == RUN);
        iact_enables = run_ok ? (src_valid & active) : '0;
        src_ready    = iact_enables & iact_readys;
    end

    // Pack the per-router set index onto the flat cluster bus.
    always_comb begin
        iact_data_set = '0;
        for (int r = 0; r < ROUTERS; r++) begin
            iact_data_set[r*SET_W +: SET_W] = set_cnt[r];
        end
    end

    // Config pulses and done are decoded from state; en=0 silences every pulse.
    assign conf_rst     = en && (state == CLR);
    assign conf_en      = en && (state == LOAD);
    assign done         = en && (state == FIN);
    assign busy         = (state != IDLE);
    assign set_done     = en ? set_done_q : '0;
    assign iact_configs = cfg_q;

    // Sequencer plus per-router element/set counters; everything holds while en=0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            active     <= '0;
            set_done_q <= '0;
            cfg_q      <= '0;
            for (int r = 0; r < ROUTERS; r++) begin
                elem_cnt[r] <= '0;
                set_cnt[r]  <= '0;
            end
        end else if (en) begin
            set_done_q <= '0;
            case (state)
                IDLE: begin
                    if (start) begin
                        cfg_q  <= cfg_in;
                        active <= router_mask;
                        for (int r = 0; r < ROUTERS; r++) begin
                            elem_cnt[r] <= '0;
                            set_cnt[r]  <= '0;
                        end
                        state <= CLR;
                    end
                end
                CLR:  state <= LOAD;
                LOAD: state <= RUN;
                RUN: begin
                    // active is the registered mask, so exit lands one cycle after the last clear.
                    if (active == '0) begin
                        state <= FIN;
                    end
                    for (int r = 0; r < ROUTERS; r++) begin
                        if (src_ready[r]) begin
                            if (elem_cnt[r] == ELEM_LAST) begin
                                elem_cnt[r]   <= '0;
                                set_done_q[r] <= 1'b1;
                                if (set_cnt[r] == SET_LAST) begin
                                    set_cnt[r] <= '0;
                                    active[r]  <= 1'b0;
                                end else begin
                                    set_cnt[r] <= set_cnt[r] + SET_ONE;
                                end
                            end else begin
                                elem_cnt[r] <= elem_cnt[r] + ELEM_ONE;
                            end
                        end
                    end
                end
                FIN:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_iact_set_scheduler.sv
// Bench for iact_set_scheduler: randomized router traffic against a fire-count based model.
module tb_iact_set_scheduler;

    localparam int ROUTERS = 3;
    localparam int SETS    = 2;
    localparam int SET_W   = 1;
    localparam int ELEMS   = 4;
    localparam int ELEM_W  = 2;
    localparam int CFG_W   = 64;
    localparam int PASS_FIRES = SETS * ELEMS;

    logic                     clk;
    logic                     rst;
    logic                     en;
    logic                     start;
    logic [CFG_W-1:0]         cfg_in;
    logic [ROUTERS-1:0]       router_mask;
    logic [ROUTERS-1:0]       src_valid;
    logic [ROUTERS-1:0]       iact_readys;
    logic [ROUTERS-1:0]       src_ready;
    logic [ROUTERS-1:0]       iact_enables;
    logic [SET_W*ROUTERS-1:0] iact_data_set;
    logic [CFG_W-1:0]         iact_configs;
    logic                     conf_rst;
    logic                     conf_en;
    logic                     busy;
    logic [ROUTERS-1:0]       set_done;
    logic                     done;

    iact_set_scheduler #(
        .ROUTERS(ROUTERS), .SETS(SETS), .SET_W(SET_W),
        .ELEMS(ELEMS), .ELEM_W(ELEM_W), .CFG_W(CFG_W)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .start(start), .cfg_in(cfg_in),
        .router_mask(router_mask), .src_valid(src_valid), .iact_readys(iact_readys),
        .src_ready(src_ready), .iact_enables(iact_enables), .iact_data_set(iact_data_set),
        .iact_configs(iact_configs), .conf_rst(conf_rst), .conf_en(conf_en),
        .busy(busy), .set_done(set_done), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: phase of the pass plus how many elements each router has delivered.
    int               m_ph;          // 0 idle, 1 clear, 2 load, 3 run, 4 fin
    logic [ROUTERS-1:0] m_mask;
    int               m_fires [ROUTERS];
    logic [CFG_W-1:0] m_cfg;
    logic [ROUTERS-1:0] m_sdp;
    logic [ROUTERS-1:0] m_act;
    logic [ROUTERS-1:0] m_rdy;

    int  vr_mode = 0;
    bit  en_rand = 0;
    bit  tog = 0;
    int  cyc = 0;
    int  obs_fires [ROUTERS];
    int  obs_done = 0;
    int  done_cyc = -1;
    int  start_cyc = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        m_ph = 0; m_mask = '0; m_cfg = '0; m_sdp = '0;
        for (int r = 0; r < ROUTERS; r++) m_fires[r] = 0;
    endtask

    task automatic clear_obs();
        obs_done = 0; done_cyc = -1;
        for (int r = 0; r < ROUTERS; r++) obs_fires[r] = 0;
    endtask

    task automatic model_update();
        if (rst) begin
            model_reset();
        end else if (en) begin
            m_sdp = '0;
            case (m_ph)
                0: if (start) begin
                       m_mask = router_mask; m_cfg = cfg_in; m_ph = 1;
                       for (int r = 0; r < ROUTERS; r++) m_fires[r] = 0;
                   end
                1: m_ph = 2;
                2: m_ph = 3;
                3: begin
                       if (m_act == '0) m_ph = 4;
                       for (int r = 0; r < ROUTERS; r++) begin
                           if (m_rdy[r]) begin
                               m_fires[r]++;
                               if (m_fires[r] % ELEMS == 0) m_sdp[r] = 1'b1;
                           end
                       end
                   end
                default: m_ph = 0;
            endcase
        end
    endtask

    // One clock: drive inputs at negedge, compare outputs, advance the model at posedge.
    task automatic cycle();
        logic [ROUTERS-1:0] e_en;
        logic [SET_W*ROUTERS-1:0] e_set;
        bit run;
        @(negedge clk);
        if (vr_mode == 1) begin
            src_valid   = ROUTERS'($urandom);
            iact_readys = ROUTERS'($urandom);
        end else if (vr_mode == 2) begin
            src_valid   = '1;
            iact_readys = {1'b1, tog, 1'b1};
            tog = ~tog;
        end else begin
            src_valid   = '1;
            iact_readys = '1;
        end
        if (en_rand) en = ($urandom_range(0, 7) != 0);
        #1;
        for (int r = 0; r < ROUTERS; r++)
            m_act[r] = m_mask[r] && (m_fires[r] < PASS_FIRES);
        run   = en && (m_ph == 3);
        e_en  = run ? (src_valid & m_act) : '0;
        m_rdy = e_en & iact_readys;
        e_set = '0;
        for (int r = 0; r < ROUTERS; r++)
            e_set[r*SET_W +: SET_W] = SET_W'((m_fires[r] / ELEMS) % SETS);
        check_val("iact_enables", 64'(iact_enables), 64'(e_en));
        check_val("src_ready", 64'(src_ready), 64'(m_rdy));
        check_val("iact_data_set", 64'(iact_data_set), 64'(e_set));
        check_val("set_done", 64'(set_done), 64'(en ? m_sdp : '0));
        check_val("conf_rst", 64'(conf_rst), 64'(en && m_ph == 1));
        check_val("conf_en", 64'(conf_en), 64'(en && m_ph == 2));
        check_val("done", 64'(done), 64'(en && m_ph == 4));
        check_val("busy", 64'(busy), 64'(m_ph != 0));
        check_val("iact_configs", iact_configs, m_cfg);
        for (int r = 0; r < ROUTERS; r++) obs_fires[r] += int'(src_ready[r]);
        if (done) begin
            obs_done++;
            done_cyc = cyc;
        end
        @(posedge clk);
        model_update();
        cyc++;
        #1;
    endtask

    task automatic start_pass(input logic [ROUTERS-1:0] mask);
        router_mask = mask;
        cfg_in = {$urandom, $urandom};
        start = 1'b1;
        for (int i = 0; i < 20 && m_ph == 0; i++) begin
            start_cyc = cyc;
            cycle();
        end
        start = 1'b0;
    endtask

    task automatic finish_pass();
        for (int i = 0; i < 400 && m_ph != 0; i++) cycle();
        check_val("pass_timeout", 64'(busy), 64'(0));
    endtask

    task automatic check_pass(input logic [ROUTERS-1:0] mask);
        check_val("done_count", 64'(obs_done), 64'(1));
        for (int r = 0; r < ROUTERS; r++)
            check_val("fires", 64'(obs_fires[r]), 64'(mask[r] ? PASS_FIRES : 0));
    endtask

    task automatic do_pass(input logic [ROUTERS-1:0] mask);
        clear_obs();
        start_pass(mask);
        finish_pass();
        check_pass(mask);
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; start = 1'b0; cfg_in = '0;
        router_mask = '0; src_valid = '0; iact_readys = '0;
        model_reset();
        m_act = '0; m_rdy = '0;
        repeat (2) @(posedge clk);
        #1;
        cycle();
        rst = 1'b0;
        repeat (2) cycle();

        // full mask, always valid/ready
        vr_mode = 0;
        do_pass(3'b111);

        // router1 ready toggles
        vr_mode = 2;
        do_pass(3'b111);

        // single router, then empty mask
        vr_mode = 1;
        do_pass(3'b010);
        vr_mode = 0;
        do_pass(3'b000);
        check_val("empty_done_lat", 64'(done_cyc - start_cyc), 64'(4));

        // start held high during RUN is ignored
        vr_mode = 1;
        clear_obs();
        start_pass(3'b111);
        for (int i = 0; i < 400 && m_ph != 0; i++) begin
            start = (m_ph == 3);
            cycle();
        end
        start = 1'b0;
        repeat (4) cycle();
        check_pass(3'b111);

        // en low for 5 cycles mid-RUN
        clear_obs();
        start_pass(3'b111);
        repeat (6) cycle();
        en = 1'b0;
        repeat (5) cycle();
        en = 1'b1;
        finish_pass();
        check_pass(3'b111);

        // reset during RUN once router0 is into set 1
        vr_mode = 0;
        clear_obs();
        start_pass(3'b111);
        for (int i = 0; i < 100 && m_fires[0] < ELEMS + 1; i++) cycle();
        check_val("t6_set1", 64'(iact_data_set[0 +: SET_W]), 64'(1));
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        repeat (3) cycle();
        check_val("t6_no_done", 64'(obs_done), 64'(0));
        do_pass(3'b111);

        // randomized passes with random stalls
        vr_mode = 1;
        en_rand = 1;
        for (int p = 0; p < 6; p++) do_pass(ROUTERS'($urandom));
        en_rand = 0;
        en = 1'b1;
        repeat (3) cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
